// File: rtl/mul_wb.sv
// Multiplier writeback stage: queues {low, high, rd, hi_en} products and drains them to the regfile port.
// Build option MUL_WB_SAT_EN: saturate the low-only write to all-ones when the high word is nonzero.
module mul_wb #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int RADDR = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            mul_rd,
    input  logic [N-1:0]            m_co,
    input  logic [RADDR-1:0]        rd_addr,
    input  logic                    hi_en,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [RADDR-1:0]        wb_addr,
    output logic [N-1:0]            wb_data,
    output logic                    wb_ovf,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // state | meaning
    // IDLE  | nothing presented, waiting for a queued entry
    // WR_LO | presenting low word of head entry to rd
    // WR_HI | presenting high word of head entry to rd+1
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    logic [N-1:0]     mem_lo   [DEPTH];
    logic [N-1:0]     mem_hi   [DEPTH];
    logic [RADDR-1:0] mem_addr [DEPTH];
    logic             mem_hien [DEPTH];

    logic [AW-1:0]    wr_ptr, rd_ptr, ld_idx;
    state_t           state, state_nx;
    logic             push, pop, full;
    logic             valid_nx, ovf_nx, ld_ovf;
    logic [RADDR-1:0] addr_nx;
    logic [N-1:0]     data_nx, ld_data;

    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_lo[wr_ptr]   <= mul_rd;
            mem_hi[wr_ptr]   <= m_co;
            mem_addr[wr_ptr] <= rd_addr;
            mem_hien[wr_ptr] <= hi_en;
        end
    end

    // From IDLE the head itself is loaded; from a pop the entry behind the head becomes the new head.
    assign ld_idx = (state == IDLE) ? rd_ptr : rd_ptr + AW'(1);

    always_comb begin
        ld_ovf  = (mem_hi[ld_idx] != '0);
        ld_data = mem_lo[ld_idx];
`ifdef MUL_WB_SAT_EN
        if (!mem_hien[ld_idx] && ld_ovf)
            ld_data = '1;
`endif
    end

    always_comb begin
        state_nx = state;
        valid_nx = wb_valid;
        addr_nx  = wb_addr;
        data_nx  = wb_data;
        ovf_nx   = wb_ovf;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = WR_LO;
                    valid_nx = 1'b1;
                    addr_nx  = mem_addr[ld_idx];
                    data_nx  = ld_data;
                    ovf_nx   = ld_ovf;
                end
            end
            WR_LO, WR_HI: begin
                if (wb_ready) begin
                    if (state == WR_LO && mem_hien[rd_ptr]) begin
                        state_nx = WR_HI;
                        addr_nx  = mem_addr[rd_ptr] + RADDR'(1);
                        data_nx  = mem_hi[rd_ptr];
                        ovf_nx   = 1'b0;
                    end else begin
                        pop = 1'b1;
                        if (count > CW'(1)) begin
                            state_nx = WR_LO;
                            valid_nx = 1'b1;
                            addr_nx  = mem_addr[ld_idx];
                            data_nx  = ld_data;
                            ovf_nx   = ld_ovf;
                        end else begin
                            state_nx = IDLE;
                            valid_nx = 1'b0;
                            ovf_nx   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
        if (flush) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            ovf_nx   = 1'b0;
            pop      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_ovf   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nx;
            wb_valid <= valid_nx;
            wb_addr  <= addr_nx;
            wb_data  <= data_nx;
            wb_ovf   <= ovf_nx;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
